// File: rtl/lsu_bus_ctrl.sv
// lsu_bus_ctrl - load/store unit bus controller.
//
// Accepts one load/store request at a time from the core. The request is
// turned into one 32-bit bus beat, or into two beats when the access
// crosses a word boundary. Load data is returned zero- or sign-extended.
// A per-beat timeout converts a bus that never answers into an error
// response.
//
// Build option:
//   LSU_MISALIGN_SPLIT_EN  defined   -> word-crossing accesses are split
//                                       into BEAT0 + BEAT1
//                          undefined -> word-crossing accesses respond
//                                       with rsp_err and no bus beat
//
// Parameter:
//   TIMEOUT_CYCLES  cycles one beat may wait for mem_ready (1..255)
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   req_valid/req_ready            request handshake (ready only in IDLE)
//   req_store, req_size            store flag; size [1:0] 00 w/01 h/10 b/11 d,
//                                  [2] sign-extend load
//   req_addr, req_wdata            byte address, LSB-aligned store data
//   stall                          high whenever not IDLE
//   rsp_valid, rsp_rdata, rsp_err  one-cycle completion
//   mem_valid/mem_ready            bus beat handshake
//   mem_we, mem_addr, mem_wstrb,
//   mem_wdata, mem_rdata           bus beat fields (word addressed)
module lsu_bus_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [2:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT0 = 2'd1,
    BEAT1 = 2'd2,
    RESP  = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic        store_q, store_d;
  logic [2:0]  size_q,  size_d;
  logic [31:0] addr_q,  addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        err_q,   err_d;
  logic [31:0] ld_q,    ld_d;
  logic [7:0]  wait_q,  wait_d;

  function automatic logic [2:0] byte_cnt(input logic [1:0] sz);
    case (sz)
      2'b10:   byte_cnt = 3'd1;
      2'b01:   byte_cnt = 3'd2;
      default: byte_cnt = 3'd4;
    endcase
  endfunction

  function automatic logic [3:0] lane_mask(input logic [1:0] sz);
    case (sz)
      2'b10:   lane_mask = 4'b0001;
      2'b01:   lane_mask = 4'b0011;
      default: lane_mask = 4'b1111;
    endcase
  endfunction

  logic [1:0]  off;
  logic [3:0]  beat0_strb;
  logic [31:0] beat0_data;
  logic        bad_req;
  logic        timed_out;
  logic [31:0] ext_data;

  assign off        = addr_q[1:0];
  assign beat0_strb = lane_mask(size_q[1:0]) << off;
  assign beat0_data = wdata_q << {off, 3'b000};
  assign timed_out  = (wait_q == 8'(TIMEOUT_CYCLES - 1));

`ifdef LSU_MISALIGN_SPLIT_EN
  logic        needs_split;
  logic [2:0]  hi_lanes;
  logic [3:0]  beat1_strb;
  logic [31:0] beat1_data;

  // Lanes that spill into the next word end up at the bottom of BEAT1, and
  // lanes of BEAT1 read data land above the 4-off bytes taken from BEAT0.
  assign hi_lanes    = 3'd4 - {1'b0, off};
  assign needs_split = ({1'b0, off} + byte_cnt(size_q[1:0])) > 3'd4;
  assign beat1_strb  = lane_mask(size_q[1:0]) >> hi_lanes;
  assign beat1_data  = wdata_q >> {hi_lanes, 3'b000};
  assign bad_req     = (req_size[1:0] == 2'b11);
`else
  logic misalign_in;
  assign misalign_in = ({1'b0, req_addr[1:0]} + byte_cnt(req_size[1:0])) > 3'd4;
  assign bad_req     = (req_size[1:0] == 2'b11) || misalign_in;
`endif

  always_comb begin
    case (size_q[1:0])
      2'b10:   ext_data = {{24{size_q[2] & ld_q[7]}},  ld_q[7:0]};
      2'b01:   ext_data = {{16{size_q[2] & ld_q[15]}}, ld_q[15:0]};
      default: ext_data = ld_q;
    endcase
  end

  // Next-state and in-flight register updates.
  always_comb begin
    state_d = state_q;
    store_d = store_q;
    size_d  = size_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    ld_d    = ld_q;
    wait_d  = wait_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          store_d = req_store;
          size_d  = req_size;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          ld_d    = '0;
          wait_d  = '0;
          err_d   = bad_req;
          state_d = bad_req ? RESP : BEAT0;
        end
      end
      BEAT0: begin
        if (mem_ready) begin
          ld_d = mem_rdata >> {off, 3'b000};
`ifdef LSU_MISALIGN_SPLIT_EN
          if (needs_split) begin
            wait_d  = '0;
            state_d = BEAT1;
          end else begin
            state_d = RESP;
          end
`else
          state_d = RESP;
`endif
        end else if (timed_out) begin
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
`ifdef LSU_MISALIGN_SPLIT_EN
      BEAT1: begin
        if (mem_ready) begin
          ld_d    = ld_q | (mem_rdata << {hi_lanes, 3'b000});
          state_d = RESP;
        end else if (timed_out) begin
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
`endif
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are pure functions of state, so they hold steady for a whole beat.
  always_comb begin
    req_ready = (state_q == IDLE);
    stall     = (state_q != IDLE);
    rsp_valid = 1'b0;
    rsp_err   = 1'b0;
    rsp_rdata = '0;
    mem_valid = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wstrb = '0;
    mem_wdata = '0;
    case (state_q)
      BEAT0: begin
        mem_valid = 1'b1;
        mem_we    = store_q;
        mem_addr  = {addr_q[31:2], 2'b00};
        mem_wstrb = beat0_strb;
        mem_wdata = beat0_data;
      end
`ifdef LSU_MISALIGN_SPLIT_EN
      BEAT1: begin
        mem_valid = 1'b1;
        mem_we    = store_q;
        mem_addr  = {addr_q[31:2], 2'b00} + 32'd4;
        mem_wstrb = beat1_strb;
        mem_wdata = beat1_data;
      end
`endif
      RESP: begin
        rsp_valid = 1'b1;
        rsp_err   = err_q;
        rsp_rdata = (err_q || store_q) ? '0 : ext_data;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      store_q <= 1'b0;
      size_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      ld_q    <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      store_q <= store_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      ld_q    <= ld_d;
      wait_q  <= wait_d;
    end
  end

endmodule

// File: tb/tb_lsu_bus_ctrl.sv
// tb_lsu_bus_ctrl - directed self-checking bench for lsu_bus_ctrl.
// Inputs are driven and outputs sampled on the falling clock edge; the DUT
// updates on the rising edge. TIMEOUT_CYCLES is set to 4.
module tb_lsu_bus_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [2:0]  req_size;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        stall;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_valid;
  logic        mem_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int unsigned n_checks = 0;
  int unsigned n_fails  = 0;

  lsu_bus_ctrl #(.TIMEOUT_CYCLES(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_store (req_store),
    .req_size  (req_size),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .stall     (stall),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wstrb (mem_wstrb),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Present a request for one cycle; returns at the falling edge after acceptance.
  task automatic issue(input logic st, input logic [2:0] sz, input logic [31:0] a, input logic [31:0] wd);
    req_valid = 1'b1;
    req_store = st;
    req_size  = sz;
    req_addr  = a;
    req_wdata = wd;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // Check the beat currently on the bus, then complete it.
  task automatic beat(input string tag, input logic we, input logic [31:0] a, input logic [3:0] strb,
                      input logic [31:0] wd, input logic [31:0] rd);
    check({tag, "_valid"}, {31'd0, mem_valid}, 32'd1);
    check({tag, "_stall"}, {31'd0, stall}, 32'd1);
    check({tag, "_we"},    {31'd0, mem_we}, {31'd0, we});
    check({tag, "_addr"},  mem_addr, a);
    check({tag, "_strb"},  {28'd0, mem_wstrb}, {28'd0, strb});
    if (we) check({tag, "_wdata"}, mem_wdata, wd);
    mem_ready = 1'b1;
    mem_rdata = rd;
    @(negedge clk);
    mem_ready = 1'b0;
    mem_rdata = 32'hDEAD_BEEF;
  endtask

  // Check the response cycle and the return to IDLE.
  task automatic resp(input string tag, input logic err, input logic [31:0] rd);
    check({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd1);
    check({tag, "_rsp_err"},   {31'd0, rsp_err}, {31'd0, err});
    check({tag, "_rsp_rdata"}, rsp_rdata, rd);
    check({tag, "_rsp_nomem"}, {31'd0, mem_valid}, 32'd0);
    @(negedge clk);
    check({tag, "_rsp_done"},  {31'd0, rsp_valid}, 32'd0);
    check({tag, "_idle"},      {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = 1'b0;
    req_store = 1'b0;
    req_size  = '0;
    req_addr  = '0;
    req_wdata = '0;
    mem_ready = 1'b0;
    mem_rdata = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_stall",     {31'd0, stall},     32'd0);
    check("rst_mem_valid", {31'd0, mem_valid}, 32'd0);
    check("rst_mem_we",    {31'd0, mem_we},    32'd0);
    check("rst_mem_wstrb", {28'd0, mem_wstrb}, 32'd0);
    check("rst_mem_addr",  mem_addr,  32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rsp_err",   {31'd0, rsp_err},   32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);

    // Store byte at offset 3.
    issue(1'b1, 3'b010, 32'h0000_1003, 32'h0000_00AB);
    beat("sb", 1'b1, 32'h0000_1000, 4'b1000, 32'hAB00_0000, 32'h0);
    resp("sb", 1'b0, 32'h0);

    // Load half, signed and unsigned.
    issue(1'b0, 3'b101, 32'h0000_2002, 32'h0);
    beat("lhs", 1'b0, 32'h0000_2000, 4'b1100, 32'h0, 32'h8001_5555);
    resp("lhs", 1'b0, 32'hFFFF_8001);
    issue(1'b0, 3'b001, 32'h0000_2002, 32'h0);
    beat("lhu", 1'b0, 32'h0000_2000, 4'b1100, 32'h0, 32'h8001_5555);
    resp("lhu", 1'b0, 32'h0000_8001);

    // Load bytes: unsigned at offset 0, signed at offset 1.
    issue(1'b0, 3'b010, 32'h0000_0010, 32'h0);
    beat("lbu", 1'b0, 32'h0000_0010, 4'b0001, 32'h0, 32'h1234_56F0);
    resp("lbu", 1'b0, 32'h0000_00F0);
    issue(1'b0, 3'b110, 32'h0000_0011, 32'h0);
    beat("lbs", 1'b0, 32'h0000_0010, 4'b0010, 32'h0, 32'h0000_8000);
    resp("lbs", 1'b0, 32'hFFFF_FF80);

    // Aligned word store and in-word half store at offset 1.
    issue(1'b1, 3'b000, 32'h0000_0040, 32'hDEAD_BEEF);
    beat("sw", 1'b1, 32'h0000_0040, 4'b1111, 32'hDEAD_BEEF, 32'h0);
    resp("sw", 1'b0, 32'h0);
    issue(1'b1, 3'b001, 32'h0000_0101, 32'h0000_1234);
    beat("sh1", 1'b1, 32'h0000_0100, 4'b0110, 32'h0012_3400, 32'h0);
    resp("sh1", 1'b0, 32'h0);

    // Word load crossing the top of the address space, and a split half store.
`ifdef LSU_MISALIGN_SPLIT_EN
    issue(1'b0, 3'b000, 32'hFFFF_FFFE, 32'h0);
    beat("lw_b0", 1'b0, 32'hFFFF_FFFC, 4'b1100, 32'h0, 32'h3344_AAAA);
    beat("lw_b1", 1'b0, 32'h0000_0000, 4'b0011, 32'h0, 32'hBBBB_1122);
    resp("lw_split", 1'b0, 32'h1122_3344);
    issue(1'b1, 3'b001, 32'h0000_0203, 32'h0000_A1B2);
    beat("sh_b0", 1'b1, 32'h0000_0200, 4'b1000, 32'hB200_0000, 32'h0);
    beat("sh_b1", 1'b1, 32'h0000_0204, 4'b0001, 32'h0000_00A1, 32'h0);
    resp("sh_split", 1'b0, 32'h0);
`else
    issue(1'b0, 3'b000, 32'hFFFF_FFFE, 32'h0);
    resp("lw_misalign", 1'b1, 32'h0);
    issue(1'b1, 3'b001, 32'h0000_0203, 32'h0000_A1B2);
    resp("sh_misalign", 1'b1, 32'h0);
`endif

    // Double-size request is rejected without a bus beat.
    issue(1'b0, 3'b011, 32'h0000_0008, 32'h0);
    resp("dbl", 1'b1, 32'h0);

    // Timeout: mem_valid high for 4 cycles, then error response. A second
    // request presented mid-beat must not disturb the in-flight beat.
    issue(1'b0, 3'b000, 32'h0000_0300, 32'h0);
    for (int unsigned i = 0; i < 4; i++) begin
      check("tmo_valid", {31'd0, mem_valid}, 32'd1);
      check("tmo_addr",  mem_addr, 32'h0000_0300);
      check("tmo_we",    {31'd0, mem_we}, 32'd0);
      if (i == 1) begin
        req_valid = 1'b1;
        req_store = 1'b1;
        req_size  = 3'b000;
        req_addr  = 32'h0000_0998;
        req_wdata = 32'h5555_5555;
      end else begin
        req_valid = 1'b0;
      end
      @(negedge clk);
    end
    resp("tmo", 1'b1, 32'h0);

    // Reset while in BEAT0 abandons the access without a response.
    issue(1'b0, 3'b000, 32'h0000_0400, 32'h0);
    check("rmid_valid", {31'd0, mem_valid}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rmid_ready",     {31'd0, req_ready}, 32'd1);
    check("rmid_mem_valid", {31'd0, mem_valid}, 32'd0);
    check("rmid_rsp",       {31'd0, rsp_valid}, 32'd0);
    @(negedge clk);
    check("rmid_rsp2",      {31'd0, rsp_valid}, 32'd0);
    check("rmid_stall",     {31'd0, stall},     32'd0);

    // Normal operation resumes after the mid-op reset.
    issue(1'b0, 3'b000, 32'h0000_0500, 32'h0);
    beat("post", 1'b0, 32'h0000_0500, 4'b1111, 32'h0, 32'hCAFE_F00D);
    resp("post", 1'b0, 32'hCAFE_F00D);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
